// File: rtl/clic_preempt_ctrl.sv
// Preemption controller behind can_clic: issues interrupt requests to the core and feeds back the threshold.
// It also keeps a LIFO of saved thresholds so that nested handlers restore the previous level on return.
module clic_preempt_ctrl #(
    parameter  int NUM_IRQ = 3,
    parameter  int PRIO_W  = 3,
    parameter  int DEPTH   = 4,
    localparam int IDX_W   = $clog2(NUM_IRQ + 1),
    localparam int DW      = $clog2(DEPTH + 1)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      is_interrupt_i,
    input  logic [IDX_W-1:0]          index_i,
    input  logic [NUM_IRQ*PRIO_W-1:0] prio_i,
    output logic [PRIO_W-1:0]         threshold_o,
    output logic                      irq_req_o,
    output logic [IDX_W-1:0]          irq_id_o,
    input  logic                      irq_ack_i,
    input  logic                      return_i,
    output logic [NUM_IRQ-1:0]        clear_pending_o,
    output logic [DW-1:0]             depth_o,
    output logic                      full_o,
    output logic                      err_o
);
    localparam int SW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, REQ, SETTLE} state_t;

    state_t              state_q, state_d;
    logic [PRIO_W-1:0]   thr_q, thr_d;
    logic                req_q, req_d;
    logic [IDX_W-1:0]    id_q, id_d;
    logic [PRIO_W-1:0]   p_q, p_d;
    logic [NUM_IRQ-1:0]  clr_q, clr_d;
    logic [DW-1:0]       depth_q, depth_d;
    logic                err_q, err_d;
    logic [PRIO_W-1:0]   stack_q [DEPTH];
    logic                push;
    logic [PRIO_W-1:0]   idx_prio;
    logic [SW-1:0]       push_ptr, pop_ptr;
    logic                full, can_pop;

    assign full     = (depth_q == DW'(DEPTH));
    assign can_pop  = (depth_q != '0);
    assign push_ptr = SW'(depth_q);
    assign pop_ptr  = SW'(depth_q - 1'b1);

    always_comb begin
        idx_prio = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (index_i == IDX_W'(i)) idx_prio = prio_i[i*PRIO_W +: PRIO_W];
        end
    end

    always_comb begin
        state_d = state_q;
        thr_d   = thr_q;
        req_d   = req_q;
        id_d    = id_q;
        p_d     = p_q;
        clr_d   = '0;
        depth_d = depth_q;
        err_d   = err_q;
        push    = 1'b0;
        case (state_q)
            IDLE: begin
                if (return_i) begin
                    if (can_pop) begin
                        thr_d   = stack_q[pop_ptr];
                        depth_d = depth_q - 1'b1;
                        state_d = SETTLE;
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (is_interrupt_i && (index_i < IDX_W'(NUM_IRQ)) && !full) begin
                    id_d    = index_i;
                    p_d     = idx_prio;
                    req_d   = 1'b1;
                    state_d = REQ;
                end
            end
            REQ: begin
                // Ack wins over a simultaneous return; the overlap itself is flagged.
                if (irq_ack_i) begin
                    push    = 1'b1;
                    thr_d   = p_q;
                    depth_d = depth_q + 1'b1;
                    req_d   = 1'b0;
                    clr_d   = NUM_IRQ'(1) << id_q;
                    state_d = SETTLE;
                    if (return_i) err_d = 1'b1;
                end else if (return_i) begin
                    if (can_pop) begin
                        thr_d   = stack_q[pop_ptr];
                        depth_d = depth_q - 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                    req_d   = 1'b0;
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                state_d = IDLE;
                if (return_i) begin
                    if (can_pop) begin
                        thr_d   = stack_q[pop_ptr];
                        depth_d = depth_q - 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            thr_q   <= '0;
            req_q   <= 1'b0;
            id_q    <= '0;
            p_q     <= '0;
            clr_q   <= '0;
            depth_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            thr_q   <= thr_d;
            req_q   <= req_d;
            id_q    <= id_d;
            p_q     <= p_d;
            clr_q   <= clr_d;
            depth_q <= depth_d;
            err_q   <= err_d;
        end
    end

    // Saved thresholds need no reset; depth_q alone says which entries are live.
    always_ff @(posedge clk) begin
        if (push) stack_q[push_ptr] <= thr_q;
    end

    assign threshold_o     = thr_q;
    assign irq_req_o       = req_q;
    assign irq_id_o        = id_q;
    assign clear_pending_o = clr_q;
    assign depth_o         = depth_q;
    assign full_o          = full;
    assign err_o           = err_q;
endmodule
